// File: rtl/stopwatch_btn_cmd.sv
// Button front end: sync + counter debounce + press edge, arbitrated into one-cycle start/stop/reset pulses.
// Pulse appears DEB_CYCLES+2 edges after a stable raw level; no backpressure, dropped presses pulse ignored.
module stopwatch_btn_cmd #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_reset_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       ignored,
  output logic [2:0] btn_level
);
  localparam int               CNT_W      = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [1:0]       ST_IDLE    = 2'b00;
  localparam logic [1:0]       ST_RUNNING = 2'b01;
  localparam logic [1:0]       ST_PAUSED  = 2'b10;
  localparam int               B_START    = 0;
  localparam int               B_STOP     = 1;
  localparam int               B_RESET    = 2;

  logic [2:0]            s1_q, s1_d;
  logic [2:0]            s2_q, s2_d;
  logic [2:0]            db_q, db_d;
  logic [2:0]            db_dly_q, db_dly_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  reset_q, reset_d;
  logic                  ignored_q, ignored_d;
  logic [2:0]            press;

  always_comb begin
    s1_d     = {btn_reset_raw, btn_stop_raw, btn_start_raw};
    s2_d     = s1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    cnt_d    = cnt_q;
    // Any sample matching the current level restarts the stability count.
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = db_q & ~db_dly_q;

  // Priority reset > stop > start; every lower-priority press in the same cycle is dropped.
  always_comb begin
    start_d   = 1'b0;
    stop_d    = 1'b0;
    reset_d   = 1'b0;
    ignored_d = 1'b0;
    if (press[B_RESET]) begin
      reset_d   = 1'b1;
      ignored_d = press[B_STOP] | press[B_START];
    end else if (press[B_STOP]) begin
      stop_d    = (status == ST_RUNNING);
      ignored_d = (status != ST_RUNNING) | press[B_START];
    end else if (press[B_START]) begin
      start_d   = (status == ST_IDLE) || (status == ST_PAUSED);
      ignored_d = !start_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      reset_q   <= 1'b0;
      ignored_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      reset_q   <= reset_d;
      ignored_q <= ignored_d;
    end
  end

  assign start     = start_q;
  assign stop      = stop_q;
  assign reset     = reset_q;
  assign ignored   = ignored_q;
  assign btn_level = db_q;

endmodule

// File: tb/tb_stopwatch_btn_cmd.sv
// Bench for stopwatch_btn_cmd at DEB_CYCLES=4: vector table, corner sequences, random run vs window model.
module tb_stopwatch_btn_cmd;
  localparam int DEB = 4;
  localparam logic [3:0] C_NONE = 4'b0000, C_START = 4'b0001, C_STOP = 4'b0010,
                         C_RESET = 4'b0100, C_IGN = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start_raw, btn_stop_raw, btn_reset_raw;
  logic [1:0] status;
  logic       start, stop, reset, ignored;
  logic [2:0] btn_level;
  logic [6:0] dut_out;

  int total = 0;
  int bad   = 0;

  stopwatch_btn_cmd #(.DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_start_raw(btn_start_raw),
    .btn_stop_raw (btn_stop_raw),
    .btn_reset_raw(btn_reset_raw),
    .status       (status),
    .start        (start),
    .stop         (stop),
    .reset        (reset),
    .ignored      (ignored),
    .btn_level    (btn_level)
  );

  always #5 clk = ~clk;
  assign dut_out = {ignored, reset, stop, start, btn_level};

  typedef struct {
    logic [2:0] raw;
    logic [1:0] st;
    logic [3:0] cmd;
    logic [2:0] lvl;
  } vec_t;
  vec_t vecs[$];

  // Model: a button's level flips once its last DEB synchronized samples all disagree with it.
  logic [DEB:0] mh [3];
  logic [2:0]   mdb, mdb_old;
  logic [3:0]   exp_cmd;
  logic [2:0]   exp_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [2:0] r);
    {btn_reset_raw, btn_stop_raw, btn_start_raw} = r;
  endtask

  task automatic push_vec(input int n, input logic [2:0] raw, input logic [1:0] st,
                          input logic [2:0] lvl, input logic [3:0] cmd);
    vec_t v;
    v.raw = raw; v.st = st; v.cmd = cmd; v.lvl = lvl;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) mh[b] = '0;
    mdb = '0;
    mdb_old = '0;
  endtask

  task automatic model_step(input logic [2:0] raw, input logic [1:0] st);
    logic [2:0] press, nxt;
    int same;
    press   = mdb & ~mdb_old;
    exp_cmd = C_NONE;
    if (press[2]) begin
      exp_cmd = C_RESET;
      if (press[1] || press[0]) exp_cmd = exp_cmd | C_IGN;
    end else if (press[1]) begin
      exp_cmd = (st == 2'b01) ? C_STOP : C_IGN;
      if (press[0]) exp_cmd = exp_cmd | C_IGN;
    end else if (press[0]) begin
      exp_cmd = (st == 2'b00 || st == 2'b10) ? C_START : C_IGN;
    end
    nxt = mdb;
    for (int b = 0; b < 3; b++) begin
      same = 0;
      for (int k = 1; k <= DEB; k++) if (mh[b][k] == mdb[b]) same++;
      if (same == 0) nxt[b] = ~mdb[b];
      mh[b] = {mh[b][DEB-1:0], raw[b]};
    end
    mdb_old = mdb;
    mdb     = nxt;
    exp_lvl = mdb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, when, igns, others, lvl_seen;
    logic [2:0] raw_r;
    logic [1:0] st_r;

    rst_n = 1'b0;
    set_raw(3'b000);
    status = 2'b00;
    #3;
    check("reset_state", dut_out, 7'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // start press while IDLE, then release
    push_vec(5, 3'b001, 2'b00, 3'b000, C_NONE);
    push_vec(1, 3'b001, 2'b00, 3'b001, C_NONE);
    push_vec(1, 3'b001, 2'b00, 3'b001, C_START);
    push_vec(3, 3'b001, 2'b00, 3'b001, C_NONE);
    push_vec(5, 3'b000, 2'b00, 3'b001, C_NONE);
    push_vec(3, 3'b000, 2'b00, 3'b000, C_NONE);
    // reset and start together while PAUSED
    push_vec(5, 3'b101, 2'b10, 3'b000, C_NONE);
    push_vec(1, 3'b101, 2'b10, 3'b101, C_NONE);
    push_vec(1, 3'b101, 2'b10, 3'b101, C_RESET | C_IGN);
    push_vec(2, 3'b101, 2'b10, 3'b101, C_NONE);
    push_vec(5, 3'b000, 2'b10, 3'b101, C_NONE);
    push_vec(2, 3'b000, 2'b10, 3'b000, C_NONE);
    // start while RUNNING is dropped
    push_vec(5, 3'b001, 2'b01, 3'b000, C_NONE);
    push_vec(1, 3'b001, 2'b01, 3'b001, C_NONE);
    push_vec(1, 3'b001, 2'b01, 3'b001, C_IGN);
    push_vec(1, 3'b001, 2'b01, 3'b001, C_NONE);
    push_vec(5, 3'b000, 2'b01, 3'b001, C_NONE);
    push_vec(2, 3'b000, 2'b01, 3'b000, C_NONE);
    // stop and start together while RUNNING
    push_vec(5, 3'b011, 2'b01, 3'b000, C_NONE);
    push_vec(1, 3'b011, 2'b01, 3'b011, C_NONE);
    push_vec(1, 3'b011, 2'b01, 3'b011, C_STOP | C_IGN);
    push_vec(5, 3'b000, 2'b01, 3'b011, C_NONE);
    push_vec(2, 3'b000, 2'b01, 3'b000, C_NONE);
    // stop while PAUSED is dropped
    push_vec(5, 3'b010, 2'b10, 3'b000, C_NONE);
    push_vec(1, 3'b010, 2'b10, 3'b010, C_NONE);
    push_vec(1, 3'b010, 2'b10, 3'b010, C_IGN);
    push_vec(5, 3'b000, 2'b10, 3'b010, C_NONE);
    push_vec(2, 3'b000, 2'b10, 3'b000, C_NONE);
    // reset with illegal status
    push_vec(5, 3'b100, 2'b11, 3'b000, C_NONE);
    push_vec(1, 3'b100, 2'b11, 3'b100, C_NONE);
    push_vec(1, 3'b100, 2'b11, 3'b100, C_RESET);
    push_vec(1, 3'b100, 2'b11, 3'b100, C_NONE);
    push_vec(5, 3'b000, 2'b11, 3'b100, C_NONE);
    push_vec(2, 3'b000, 2'b11, 3'b000, C_NONE);

    foreach (vecs[i]) begin
      set_raw(vecs[i].raw);
      status = vecs[i].st;
      tick();
      check($sformatf("vec[%0d]", i), dut_out, {vecs[i].cmd, vecs[i].lvl});
    end

    // glitch shorter than DEB samples
    status = 2'b00;
    pulses = 0; lvl_seen = 0;
    for (int k = 0; k < 12; k++) begin
      btn_start_raw = (k < 3);
      tick();
      if (start) pulses++;
      if (btn_level[0]) lvl_seen++;
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_level", lvl_seen, 0);

    // bouncing stop button, then held
    status = 2'b01;
    pulses = 0; when = -1; igns = 0; others = 0;
    for (int k = 0; k < 12; k++) begin
      btn_stop_raw = ((k / 2) % 2 == 0);
      tick();
      if (stop) pulses++;
      if (ignored) igns++;
      if (start || reset) others++;
    end
    btn_stop_raw = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (stop) begin pulses++; when = k; end
      if (ignored) igns++;
      if (start || reset) others++;
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_when", when, 6);
    check("bounce_ignored", igns, 0);
    check("bounce_others", others, 0);
    btn_stop_raw = 1'b0;
    repeat (8) tick();

    // reset mid-debounce with start held, pulse after deassert, async clear of a live pulse
    status = 2'b00;
    btn_start_raw = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check("rst_mid", dut_out, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    when = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (start) begin when = e; break; end
    end
    check("held_rst_when", when, 6);
    #2 rst_n = 1'b0;
    #1 check("rst_async_clear", dut_out, 7'd0);
    btn_start_raw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // random run against the model
    raw_r = 3'b000;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) raw_r[b] = ~raw_r[b];
      if ($urandom_range(0, 19) == 0) raw_r = {3{1'($urandom_range(0, 1))}};
      st_r = 2'($urandom_range(0, 3));
      set_raw(raw_r);
      status = st_r;
      model_step(raw_r, st_r);
      tick();
      check($sformatf("rand[%0d]", n), dut_out, {exp_cmd, exp_lvl});
      if (n == 400) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rand_rst", dut_out, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
